// File: rtl/qspi_flash_resp.sv
// qspi_flash_resp: single-lane SPI flash responder for the e203 QSPI0 pads.
// Oversamples SCK/CS/DQ0 in the clk domain, decodes mode-0 commands
// READ (03), RDID (9F) and RDSR (05), and streams bytes MSB first on DQ1
// from a synchronous-read memory port (data valid one clk after mem_req).
// Ports:
//   clk, rst_n          responder clock, async active-low reset
//   qspi_sck/cs_n/dq0_i SPI inputs from the SoC pads (asynchronous)
//   qspi_dq1_o/dq1_oe   MISO value and output enable
//   mem_req/mem_addr    one-cycle read strobe and byte address
//   mem_rdata           read data, sampled one clk after mem_req
//   busy                high whenever the responder is not idle
module qspi_flash_resp #(
   parameter int unsigned ADDR_W   = 24,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              qspi_sck,
   input  logic              qspi_cs_n,
   input  logic              qspi_dq0_i,
   output logic              qspi_dq1_o,
   output logic              qspi_dq1_oe,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_ID     = 3'd4;
   localparam logic [2:0] S_STAT   = 3'd5;
   localparam logic [2:0] S_IGNORE = 3'd6;

   // synchronizers; third stage on sck and cs_n provides edge detection
   logic [2:0]        r_sck_sync, r_cs_sync;
   logic [1:0]        r_dq0_sync;

   logic [2:0]        r_state,   w_state_nxt;
   logic [4:0]        r_bit_cnt, w_bit_cnt_nxt;
   logic [22:0]       r_in,      w_in_nxt;
   logic [7:0]        r_sr,      w_sr_nxt;
   logic [2:0]        r_obit,    w_obit_nxt;
   logic [1:0]        r_id_idx,  w_id_idx_nxt;
   logic [7:0]        r_pref,    w_pref_nxt;
   logic              r_rd_pend, w_rd_pend_nxt;
   logic              r_rd_dst,  w_rd_dst_nxt;
   logic              r_dq1,     w_dq1_nxt;
   logic              r_oe,      w_oe_nxt;
   logic              r_req,     w_req_nxt;
   logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
   logic              r_busy,    w_busy_nxt;

   logic              w_sck_rise, w_sck_fall, w_cs_n, w_cs_fall, w_dq0;
   logic [7:0]        w_cmd, w_id_byte;
   logic [23:0]       w_addr24;

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
   assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
   assign w_cs_n     = r_cs_sync[1];
   assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
   assign w_dq0      = r_dq0_sync[1];
   assign w_cmd      = {r_in[6:0], w_dq0};
   assign w_addr24   = {r_in, w_dq0};

   // RDID byte selector, index 2 is the MSB byte
   always_comb begin
      case (r_id_idx)
         2'd2:    w_id_byte = JEDEC_ID[23:16];
         2'd1:    w_id_byte = JEDEC_ID[15:8];
         default: w_id_byte = JEDEC_ID[7:0];
      endcase
   end

   // next-state and output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_in_nxt      = r_in;
      w_sr_nxt      = r_sr;
      w_obit_nxt    = r_obit;
      w_id_idx_nxt  = r_id_idx;
      w_pref_nxt    = r_pref;
      w_rd_pend_nxt = r_req;
      w_rd_dst_nxt  = r_rd_dst;
      w_dq1_nxt     = r_dq1;
      w_oe_nxt      = r_oe;
      w_req_nxt     = 1'b0;
      w_addr_nxt    = r_addr;

      if (w_cs_n) begin
         // deselect wins over any same-cycle sck edge; drops in-flight reads
         w_state_nxt   = S_IDLE;
         w_bit_cnt_nxt = 5'd0;
         w_obit_nxt    = 3'd0;
         w_rd_pend_nxt = 1'b0;
         w_dq1_nxt     = 1'b0;
         w_oe_nxt      = 1'b0;
      end else begin
         // read data returns two clk after the strobe was registered
         if (r_rd_pend) begin
            if (r_rd_dst) w_sr_nxt   = mem_rdata;
            else          w_pref_nxt = mem_rdata;
         end

         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  w_state_nxt   = S_CMD;
                  w_bit_cnt_nxt = 5'd0;
               end
            end
            S_CMD: begin
               if (w_sck_rise) begin
                  w_in_nxt      = {r_in[21:0], w_dq0};
                  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                  if (r_bit_cnt == 5'd7) begin
                     w_bit_cnt_nxt = 5'd0;
                     w_obit_nxt    = 3'd0;
                     case (w_cmd)
                        8'h03: w_state_nxt = S_ADDR;
                        8'h9F: begin
                           w_state_nxt  = S_ID;
                           w_sr_nxt     = JEDEC_ID[23:16];
                           w_id_idx_nxt = 2'd1;
                        end
                        8'h05: begin
                           w_state_nxt = S_STAT;
                           w_sr_nxt    = 8'h00;
                        end
                        default: w_state_nxt = S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               if (w_sck_rise) begin
                  w_in_nxt      = {r_in[21:0], w_dq0};
                  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                  if (r_bit_cnt == 5'd23) begin
                     w_state_nxt   = S_DATA;
                     w_bit_cnt_nxt = 5'd0;
                     w_req_nxt     = 1'b1;
                     w_addr_nxt    = ADDR_W'(w_addr24);
                     w_rd_dst_nxt  = 1'b1;
                  end
               end
            end
            S_DATA, S_ID, S_STAT: begin
               if (w_sck_fall) begin
                  w_dq1_nxt  = r_sr[7];
                  w_oe_nxt   = 1'b1;
                  w_sr_nxt   = {r_sr[6:0], 1'b0};
                  w_obit_nxt = r_obit + 3'd1;
                  // driving bit 7: prefetch the next byte
                  if (r_state == S_DATA && r_obit == 3'd0) begin
                     w_req_nxt    = 1'b1;
                     w_addr_nxt   = r_addr + ADDR_W'(1);
                     w_rd_dst_nxt = 1'b0;
                  end
                  // driving bit 0: queue the next byte
                  if (r_obit == 3'd7) begin
                     if (r_state == S_DATA) begin
                        w_sr_nxt = r_pref;
                     end else if (r_state == S_ID) begin
                        w_sr_nxt     = w_id_byte;
                        w_id_idx_nxt = (r_id_idx == 2'd0) ? 2'd2 : r_id_idx - 2'd1;
                     end else begin
                        w_sr_nxt = 8'h00;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_sync <= 3'b000;
         r_cs_sync  <= 3'b111;
         r_dq0_sync <= 2'b00;
         r_state    <= S_IDLE;
         r_bit_cnt  <= 5'd0;
         r_in       <= 23'd0;
         r_sr       <= 8'd0;
         r_obit     <= 3'd0;
         r_id_idx   <= 2'd0;
         r_pref     <= 8'd0;
         r_rd_pend  <= 1'b0;
         r_rd_dst   <= 1'b0;
         r_dq1      <= 1'b0;
         r_oe       <= 1'b0;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[1:0], qspi_sck};
         r_cs_sync  <= {r_cs_sync[1:0], qspi_cs_n};
         r_dq0_sync <= {r_dq0_sync[0], qspi_dq0_i};
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_in       <= w_in_nxt;
         r_sr       <= w_sr_nxt;
         r_obit     <= w_obit_nxt;
         r_id_idx   <= w_id_idx_nxt;
         r_pref     <= w_pref_nxt;
         r_rd_pend  <= w_rd_pend_nxt;
         r_rd_dst   <= w_rd_dst_nxt;
         r_dq1      <= w_dq1_nxt;
         r_oe       <= w_oe_nxt;
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign qspi_dq1_o  = r_dq1;
   assign qspi_dq1_oe = r_oe;
   assign mem_req     = r_req;
   assign mem_addr    = r_addr;
   assign busy        = r_busy;

endmodule

// File: tb/tb_qspi_flash_resp.sv
// Directed testbench for qspi_flash_resp: a 24-bit-address instance and an
// 8-bit-address instance share the SPI pins; each has its own memory model
// and request log. SPI master runs mode 0 with a half-period of H clk.
module tb_qspi_flash_resp;

   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sck, cs_n, dq0;
   logic        dq1, oe, req, busy;
   logic [23:0] addr;
   logic [7:0]  rdata;
   logic        dq1_8, oe_8, req_8, busy_8;
   logic [7:0]  addr_8;
   logic [7:0]  rdata_8;

   logic [7:0]  mem [0:255];
   logic [23:0] log24 [0:63];
   logic [7:0]  log8  [0:63];
   int          n24 = 0;
   int          n8  = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   qspi_flash_resp #(.ADDR_W(24), .JEDEC_ID(24'hEF4016)) dut (
      .clk(clk), .rst_n(rst_n), .qspi_sck(sck), .qspi_cs_n(cs_n),
      .qspi_dq0_i(dq0), .qspi_dq1_o(dq1), .qspi_dq1_oe(oe),
      .mem_req(req), .mem_addr(addr), .mem_rdata(rdata), .busy(busy));

   qspi_flash_resp #(.ADDR_W(8), .JEDEC_ID(24'hEF4016)) dut8 (
      .clk(clk), .rst_n(rst_n), .qspi_sck(sck), .qspi_cs_n(cs_n),
      .qspi_dq0_i(dq0), .qspi_dq1_o(dq1_8), .qspi_dq1_oe(oe_8),
      .mem_req(req_8), .mem_addr(addr_8), .mem_rdata(rdata_8), .busy(busy_8));

   // synchronous-read memories with request logs
   always @(posedge clk) begin
      if (req) begin
         rdata <= mem[addr[7:0]];
         if (n24 < 64) log24[n24] <= addr;
         n24 <= n24 + 1;
      end
      if (req_8) begin
         rdata_8 <= mem[addr_8];
         if (n8 < 64) log8[n8] <= addr_8;
         n8 <= n8 + 1;
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int n,
                           output logic [7:0] rx, output logic [7:0] rx8,
                           output logic oe_any, output logic oe_all);
      rx = 8'h00; rx8 = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
      for (int i = 7; i > 7 - n; i--) begin
         dq0 = tx[i];
         repeat (H) @(negedge clk);
         sck = 1'b1;
         rx[i]  = dq1;
         rx8[i] = dq1_8;
         oe_any = oe_any | oe;
         oe_all = oe_all & oe;
         repeat (H) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      repeat (3 * H) @(negedge clk);
   endtask

   // sends a command and 24-bit address, returns whether oe was ever seen
   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, output logic oe_seen);
      logic [7:0] rx, rx8, b;
      logic any, all;
      oe_seen = 1'b0;
      spi_bits(cmd, 8, rx, rx8, any, all);
      oe_seen = oe_seen | any;
      for (int k = 0; k < 3; k++) begin
         b = a[23 - 8 * k -: 8];
         spi_bits(b, 8, rx, rx8, any, all);
         oe_seen = oe_seen | any;
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (dq1 !== 1'b0)    begin n_err++; $display("FAIL reset_dq1: got %b exp 0", dq1); end
      n_cmp++; if (oe !== 1'b0)     begin n_err++; $display("FAIL reset_oe: got %b exp 0", oe); end
      n_cmp++; if (req !== 1'b0)    begin n_err++; $display("FAIL reset_req: got %b exp 0", req); end
      n_cmp++; if (addr !== 24'h0)  begin n_err++; $display("FAIL reset_addr: got %h exp 000000", addr); end
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_cmp++; if (busy_8 !== 1'b0 || oe_8 !== 1'b0)
         begin n_err++; $display("FAIL reset_dut8: got busy=%b oe=%b exp 0 0", busy_8, oe_8); end
   endtask

   task automatic test_read();
      logic [7:0] exp_d [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
      logic [7:0] rx, rx8;
      logic any, all, hdr_oe;
      int base;
      base = n24;
      cs_begin();
      send_hdr(8'h03, 24'h000010, hdr_oe);
      n_cmp++; if (hdr_oe !== 1'b0) begin n_err++; $display("FAIL read_hdr_oe: got %b exp 0", hdr_oe); end
      for (int k = 0; k < 4; k++) begin
         spi_bits(8'h00, 8, rx, rx8, any, all);
         n_cmp++; if (rx !== exp_d[k]) begin n_err++; $display("FAIL read_byte%0d: got %h exp %h", k, rx, exp_d[k]); end
         n_cmp++; if (all !== 1'b1) begin n_err++; $display("FAIL read_oe%0d: got %b exp 1", k, all); end
      end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy: got %b exp 1", busy); end
      cs_end();
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (log24[base + k] !== 24'h000010 + 24'(k))
            begin n_err++; $display("FAIL read_addr%0d: got %h exp %h", k, log24[base + k], 24'h000010 + 24'(k)); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_d [3] = '{8'h9B, 8'h64, 8'hD2};
      logic [7:0] exp_a8 [3] = '{8'hFE, 8'hFF, 8'h00};
      logic [23:0] exp_a24 [3] = '{24'h0000FE, 24'h0000FF, 24'h000100};
      logic [7:0] rx, rx8;
      logic any, all, hdr_oe;
      int b24, b8;
      b24 = n24; b8 = n8;
      cs_begin();
      send_hdr(8'h03, 24'h0000FE, hdr_oe);
      for (int k = 0; k < 3; k++) begin
         spi_bits(8'h00, 8, rx, rx8, any, all);
         n_cmp++; if (rx8 !== exp_d[k]) begin n_err++; $display("FAIL wrap_byte%0d: got %h exp %h", k, rx8, exp_d[k]); end
      end
      cs_end();
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (log8[b8 + k] !== exp_a8[k])
            begin n_err++; $display("FAIL wrap_addr8_%0d: got %h exp %h", k, log8[b8 + k], exp_a8[k]); end
         n_cmp++; if (log24[b24 + k] !== exp_a24[k])
            begin n_err++; $display("FAIL wrap_addr24_%0d: got %h exp %h", k, log24[b24 + k], exp_a24[k]); end
      end
   endtask

   task automatic test_rdid();
      logic [7:0] exp_d [4] = '{8'hEF, 8'h40, 8'h16, 8'hEF};
      logic [7:0] rx, rx8;
      logic any, all;
      int base;
      base = n24;
      cs_begin();
      spi_bits(8'h9F, 8, rx, rx8, any, all);
      for (int k = 0; k < 4; k++) begin
         spi_bits(8'h00, 8, rx, rx8, any, all);
         n_cmp++; if (rx !== exp_d[k]) begin n_err++; $display("FAIL rdid_byte%0d: got %h exp %h", k, rx, exp_d[k]); end
      end
      cs_end();
      n_cmp++; if (n24 !== base) begin n_err++; $display("FAIL rdid_noreq: got %0d reqs exp 0", n24 - base); end
   endtask

   task automatic test_rdsr();
      logic [7:0] rx, rx8;
      logic any, all;
      cs_begin();
      spi_bits(8'h05, 8, rx, rx8, any, all);
      for (int k = 0; k < 2; k++) begin
         spi_bits(8'h00, 8, rx, rx8, any, all);
         n_cmp++; if (rx !== 8'h00 || all !== 1'b1)
            begin n_err++; $display("FAIL rdsr_byte%0d: got %h oe=%b exp 00 oe=1", k, rx, all); end
      end
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL rdsr_oe_2clk: got %b exp 1", oe); end
      @(negedge clk);
      n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL rdsr_oe_3clk: got %b exp 0", oe); end
      repeat (3 * H) @(negedge clk);
   endtask

   task automatic test_unknown();
      logic [7:0] rx, rx8;
      logic any, all, seen;
      seen = 1'b0;
      cs_begin();
      for (int k = 0; k < 3; k++) begin
         spi_bits((k == 0) ? 8'hAB : 8'hFF, 8, rx, rx8, any, all);
         seen = seen | any;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL unk_oe: got %b exp 0", seen); end
      repeat (H) @(negedge clk);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL unk_busy_2clk: got %b exp 1", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL unk_busy_3clk: got %b exp 0", busy); end
      repeat (3 * H) @(negedge clk);
   endtask

   task automatic test_abort();
      logic [7:0] rx, rx8;
      logic any, all, seen, hdr_oe;
      int base;
      base = n24;
      seen = 1'b0;
      cs_begin();
      spi_bits(8'h03, 8, rx, rx8, any, all); seen = seen | any;
      spi_bits(8'h00, 8, rx, rx8, any, all); seen = seen | any;
      spi_bits(8'h00, 4, rx, rx8, any, all); seen = seen | any;
      cs_end();
      n_cmp++; if (n24 !== base) begin n_err++; $display("FAIL abort_noreq: got %0d reqs exp 0", n24 - base); end
      n_cmp++; if (seen !== 1'b0 || oe !== 1'b0) begin n_err++; $display("FAIL abort_oe: got %b exp 0", seen | oe); end
      cs_begin();
      send_hdr(8'h03, 24'h000020, hdr_oe);
      spi_bits(8'h00, 8, rx, rx8, any, all);
      cs_end();
      n_cmp++; if (rx !== 8'h77) begin n_err++; $display("FAIL abort_read: got %h exp 77", rx); end
      n_cmp++; if (log24[base] !== 24'h000020) begin n_err++; $display("FAIL abort_addr: got %h exp 000020", log24[base]); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d [4] = '{8'hD2, 8'h4E, 8'h8F, 8'h10};
      logic [7:0] rx, rx8;
      logic any, all, hdr_oe;
      cs_begin();
      send_hdr(8'h03, 24'h000010, hdr_oe);
      spi_bits(8'h00, 8, rx, rx8, any, all);
      spi_bits(8'h00, 4, rx, rx8, any, all);
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sck   = 1'b0;
      #1;
      n_cmp++; if (dq1 !== 1'b0 || oe !== 1'b0 || req !== 1'b0 || busy !== 1'b0)
         begin n_err++; $display("FAIL rstmid_outs: got dq1=%b oe=%b req=%b busy=%b exp 0 0 0 0", dq1, oe, req, busy); end
      n_cmp++; if (addr !== 24'h0) begin n_err++; $display("FAIL rstmid_addr: got %h exp 000000", addr); end
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      cs_begin();
      send_hdr(8'h03, 24'h000000, hdr_oe);
      for (int k = 0; k < 4; k++) begin
         spi_bits(8'h00, 8, rx, rx8, any, all);
         n_cmp++; if (rx !== exp_d[k]) begin n_err++; $display("FAIL rstmid_byte%0d: got %h exp %h", k, rx, exp_d[k]); end
      end
      cs_end();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
      mem[8'h10] = 8'hA5; mem[8'h11] = 8'h5A; mem[8'h12] = 8'h3C; mem[8'h13] = 8'hC3;
      mem[8'hFE] = 8'h9B; mem[8'hFF] = 8'h64; mem[8'h00] = 8'hD2;
      mem[8'h01] = 8'h4E; mem[8'h02] = 8'h8F; mem[8'h03] = 8'h10;
      mem[8'h20] = 8'h77;
      rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; dq0 = 1'b0;
      repeat (4) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      test_read();
      test_wrap();
      test_rdid();
      test_rdsr();
      test_unknown();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
